// File: rtl/seq_detect_arbiter_pkg.sv
// Shared definitions for the seq_detect_arbiter slice.
// Provides the sequencer and detector state encodings, the requester count,
// default word width and pattern, the match counter width, and two helpers:
// a saturating counter increment and the detector's overlap transition.
package seq_arb_pkg;

    localparam int unsigned N_REQ       = 4;
    localparam int unsigned REQ_W       = 2;
    localparam int unsigned DEF_WIDTH   = 8;
    localparam logic [3:0]  DEF_PATTERN = 4'b1011;
    localparam int unsigned CNT_W       = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        REPORT
    } arb_state_e;

    // Detector state = number of pattern bits currently matched.
    typedef enum logic [1:0] {
        DET_S0,
        DET_S1,
        DET_S2,
        DET_S3
    } det_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // One detector step: returns {full_match, next_matched_len}.
    // The history is the matched prefix of pat followed by b; the next state
    // is the longest proper suffix of that history that is a prefix of pat,
    // which is what makes overlapping occurrences count.
    function automatic logic [2:0] det_step(input logic [3:0] pat,
                                            input logic [1:0] st,
                                            input logic       b);
        logic [4:0] p5;
        logic [4:0] hv;
        logic [4:0] mask;
        logic [4:0] want;
        logic [1:0] nxt;
        logic       full;
        p5   = {1'b0, pat};
        hv   = ((p5 >> (4 - int'(st))) << 1) | 5'(b);
        nxt  = 2'd0;
        full = 1'b0;
        mask = '0;
        want = '0;
        for (int k = 1; k <= 4; k++) begin
            if (k <= int'(st) + 1) begin
                mask = 5'((1 << k) - 1);
                want = p5 >> (4 - k);
                if ((hv & mask) == want) begin
                    if (k == 4) begin
                        full = 1'b1;
                    end else begin
                        nxt = 2'(k);
                    end
                end
            end
        end
        return {full, nxt};
    endfunction

endpackage

// File: rtl/seq_detect_arbiter_if.sv
// Requester-side bus of seq_detect_arbiter.
//   req[N_REQ]            job request per requester
//   data[N_REQ*WIDTH]     requester i word at [WIDTH*i +: WIDTH]
//   grant[N_REQ]          one-hot owner of the detector
//   busy                  job in progress
//   done                  one-cycle result strobe
//   done_id, match_count  result, held until the next report
// master = requester side, slave = arbiter side.
interface seq_detect_arbiter_if #(
    parameter int unsigned WIDTH = seq_arb_pkg::DEF_WIDTH
);

    logic [seq_arb_pkg::N_REQ-1:0]       req;
    logic [seq_arb_pkg::N_REQ*WIDTH-1:0] data;
    logic [seq_arb_pkg::N_REQ-1:0]       grant;
    logic                                busy;
    logic                                done;
    logic [seq_arb_pkg::REQ_W-1:0]       done_id;
    logic [seq_arb_pkg::CNT_W-1:0]       match_count;

    modport master (
        output req, data,
        input  grant, busy, done, done_id, match_count
    );

    modport slave (
        input  req, data,
        output grant, busy, done, done_id, match_count
    );

endinterface

// File: rtl/seq_detect_arbiter_pattern_detector.sv
// Serial overlapping detector for a 4-bit pattern, MSB received first.
//   clk, reset  clock and synchronous active-high reset
//   clear       synchronous return to the start state
//   in          serial bit
//   out         registered pulse the cycle after the bit completing PATTERN
module pattern_detector
    import seq_arb_pkg::*;
#(
    parameter logic [3:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic in,
    output logic out
);

    det_state_e state_q, state_d;
    logic       out_q, out_d;
    logic [2:0] step_c;

    // State and pulse registers.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q <= DET_S0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // Transition and pulse generation.
    always_comb begin
        state_d = state_q;
        out_d   = 1'b0;
        step_c  = det_step(PATTERN, state_q, in);
        state_d = det_state_e'(step_c[1:0]);
        out_d   = step_c[2];
    end

    assign out = out_q;

endmodule

// File: rtl/seq_detect_arbiter.sv
// Round-robin arbiter sharing one serial pattern detector among N_REQ
// requesters. A granted word is latched, cleared into the detector, shifted
// MSB first, drained one cycle and its overlapping match count reported.
//   clk, reset  clock and synchronous active-high reset
//   bus         seq_detect_arbiter_if slave: req/data in,
//               grant/busy/done/done_id/match_count out (all registered)
module seq_detect_arbiter
    import seq_arb_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter logic [3:0]  PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic reset,
    seq_detect_arbiter_if.slave bus
);

    localparam int unsigned      IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    arb_state_e       state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] mc_q, mc_d;
    logic [REQ_W-1:0] owner_q, owner_d;
    logic [REQ_W-1:0] last_q, last_d;
    logic [REQ_W-1:0] done_id_q, done_id_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] words_c [N_REQ];
    logic             sel_vld_c;
    logic [REQ_W-1:0] sel_idx_c;
    logic [REQ_W-1:0] cand_c;
    logic             det_clear_c;
    logic             det_in_c;
    logic             det_out;

    // Split the flat data bus into per-requester words.
    always_comb begin
        for (int i = 0; i < int'(N_REQ); i++) begin
            words_c[i] = bus.data[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin pick: first active request after the last grant, wrapping.
    always_comb begin
        sel_vld_c = 1'b0;
        sel_idx_c = '0;
        cand_c    = '0;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            cand_c = last_q + REQ_W'(i);
            if (!sel_vld_c && bus.req[cand_c]) begin
                sel_vld_c = 1'b1;
                sel_idx_c = cand_c;
            end
        end
    end

    pattern_detector #(
        .PATTERN (PATTERN)
    ) u_det (
        .clk   (clk),
        .reset (reset),
        .clear (det_clear_c),
        .in    (det_in_c),
        .out   (det_out)
    );

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            word_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            owner_q   <= '0;
            last_q    <= REQ_W'(N_REQ - 1);
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            mc_q      <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            mc_q      <= mc_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        last_d      = last_q;
        grant_d     = grant_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        mc_d        = mc_q;
        det_clear_c = 1'b0;
        det_in_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_vld_c) begin
                    state_d = CLEAR;
                    word_d  = words_c[sel_idx_c];
                    owner_d = sel_idx_c;
                    last_d  = sel_idx_c;
                    grant_d = N_REQ'(1) << sel_idx_c;
                end
            end
            CLEAR: begin
                det_clear_c = 1'b1;
                cnt_d       = '0;
                idx_d       = IDX_TOP;
                state_d     = SHIFT;
            end
            SHIFT: begin
                det_in_c = word_q[idx_q];
                // The first shift cycle sees the pulse register just cleared.
                if (det_out && (idx_q != IDX_TOP)) begin
                    cnt_d = sat_inc(cnt_q);
                end
                if (idx_q == '0) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            DRAIN: begin
                // Fold in the pulse produced by the final bit.
                cnt_d     = det_out ? sat_inc(cnt_q) : cnt_q;
                mc_d      = cnt_d;
                done_d    = 1'b1;
                done_id_d = owner_q;
                state_d   = REPORT;
            end
            REPORT: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.grant       = grant_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.done_id     = done_id_q;
    assign bus.match_count = mc_q;

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Self-checking bench for seq_detect_arbiter: directed scenarios with literal
// expectations plus a randomized phase compared every cycle against a
// job-level model (round-robin pick, fixed job length, window-scan count).
module tb_seq_detect_arbiter;

    localparam int unsigned WIDTH   = 8;
    localparam logic [3:0]  PATTERN = 4'b1011;
    localparam int          JOB_LEN = WIDTH + 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seq_detect_arbiter_if #(.WIDTH(WIDTH)) bus ();

    seq_detect_arbiter #(
        .WIDTH   (WIDTH),
        .PATTERN (PATTERN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Overlapping occurrences of PATTERN in a word, MSB first, saturating at 7.
    function automatic int count_matches(input logic [WIDTH-1:0] w);
        int c = 0;
        for (int p = WIDTH - 1; p >= 3; p--) begin
            if (w[p -: 4] == PATTERN) c++;
        end
        if (c > 7) c = 7;
        return c;
    endfunction

    function automatic int owner_of(input logic [3:0] g);
        case (g)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return 9;
        endcase
    endfunction

    // Job-level reference model.
    bit               chk_en = 1'b0;
    bit               m_active;
    int               m_age;
    int               m_owner;
    int               m_last;
    int               m_done_id;
    int               m_mc;
    logic [WIDTH-1:0] m_word;
    logic [3:0]       exp_grant;
    logic             exp_busy;
    logic             exp_done;

    always @(posedge clk) begin
        if (reset) begin
            m_active  = 1'b0;
            m_age     = 0;
            m_owner   = 0;
            m_last    = 3;
            m_done_id = 0;
            m_mc      = 0;
            chk_en    = 1'b1;
        end else if (m_active) begin
            m_age++;
            if (m_age == JOB_LEN) begin
                m_active = 1'b0;
            end else if (m_age == JOB_LEN - 1) begin
                m_done_id = m_owner;
                m_mc      = count_matches(m_word);
            end
        end else if (bus.req != 4'b0) begin
            for (int i = 1; i <= 4; i++) begin
                if (!m_active && bus.req[(m_last + i) % 4]) begin
                    m_active = 1'b1;
                    m_owner  = (m_last + i) % 4;
                end
            end
            m_last = m_owner;
            m_age  = 0;
            m_word = bus.data[m_owner*WIDTH +: WIDTH];
        end
        exp_grant = m_active ? 4'(1 << m_owner) : 4'b0;
        exp_busy  = m_active;
        exp_done  = m_active && (m_age == JOB_LEN - 1);
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_grant",   32'(bus.grant),       32'(exp_grant));
            chk("m_busy",    32'(bus.busy),        32'(exp_busy));
            chk("m_done",    32'(bus.done),        32'(exp_done));
            chk("m_done_id", 32'(bus.done_id),     32'(m_done_id));
            chk("m_count",   32'(bus.match_count), 32'(m_mc));
        end
    end

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    // Called at the negedge where grant is first visible; returns edges to done.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_job(input logic [3:0] r, input int id, input logic [WIDTH-1:0] w,
                           input int exp_mc, input string nm);
        int cyc;
        bus.data[id*WIDTH +: WIDTH] = w;
        bus.req = r;
        @(negedge clk);
        chk({nm, "_grant"}, 32'(bus.grant), 32'(r));
        wait_done(cyc);
        chk({nm, "_lat"}, 32'(cyc), 32'(WIDTH + 2));
        chk({nm, "_id"}, 32'(bus.done_id), 32'(id));
        chk({nm, "_count"}, 32'(bus.match_count), 32'(exp_mc));
        bus.req = 4'b0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int own;
        logic [WIDTH-1:0] w;

        reset    = 1'b1;
        bus.req  = 4'b0;
        bus.data = '0;
        @(negedge clk);
        do_reset(2);

        // Reset values.
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_id", 32'(bus.done_id), 32'h0);
        chk("rst_count", 32'(bus.match_count), 32'h0);

        // Single job on requester 0 with an overlapping pair of matches.
        bus.data[WIDTH-1:0] = 8'b1011_0110;
        bus.req = 4'b0001;
        @(negedge clk);
        for (int n = 0; n < 11; n++) begin
            if (n > 0) @(negedge clk);
            chk("t1_grant", 32'(bus.grant), 32'h1);
            chk("t1_done", 32'(bus.done), 32'(n == 10));
        end
        chk("t1_id", 32'(bus.done_id), 32'h0);
        chk("t1_count", 32'(bus.match_count), 32'h2);
        bus.req = 4'b0;
        @(negedge clk);
        chk("t1_idle_grant", 32'(bus.grant), 32'h0);
        chk("t1_hold_count", 32'(bus.match_count), 32'h2);

        // Requester 1, no match then two matches.
        run_job(4'b0010, 1, 8'h00, 0, "t2a");
        run_job(4'b0010, 1, 8'b1011_1011, 2, "t2b");

        // All requesting from reset: order 0,1,2,3,0 with one idle cycle between.
        bus.req  = 4'b1111;
        bus.data = 32'($urandom);
        do_reset(2);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            own = owner_of(bus.grant);
            chk("t3_order", 32'(own), 32'(j % 4));
            wait_done(cyc);
            chk("t3_lat", 32'(cyc), 32'(WIDTH + 2));
            if (j == 4) bus.req = 4'b0;
            @(negedge clk);
            chk("t3_gap_grant", 32'(bus.grant), 32'h0);
            chk("t3_gap_busy", 32'(bus.busy), 32'h0);
        end

        // Reset during the 4th shift cycle aborts the job.
        bus.data[WIDTH-1:0] = 8'b1011_0110;
        bus.req = 4'b0001;
        @(negedge clk);
        chk("t4_grant", 32'(bus.grant), 32'h1);
        repeat (4) @(negedge clk);
        chk("t4_busy_mid", 32'(bus.busy), 32'h1);
        reset   = 1'b1;
        bus.req = 4'b0;
        @(negedge clk);
        chk("t4_grant_off", 32'(bus.grant), 32'h0);
        chk("t4_busy_off", 32'(bus.busy), 32'h0);
        chk("t4_done_off", 32'(bus.done), 32'h0);
        chk("t4_count_rst", 32'(bus.match_count), 32'h0);
        reset = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            chk("t4_no_done", 32'(bus.done), 32'h0);
        end
        run_job(4'b0001, 0, 8'b1011_0110, 2, "t4_rerun");

        // Owner drops req and the bus changes mid-shift.
        bus.data[2*WIDTH +: WIDTH] = 8'b1011_1011;
        bus.req = 4'b0100;
        @(negedge clk);
        chk("t5_grant", 32'(bus.grant), 32'h4);
        repeat (3) @(negedge clk);
        bus.req  = 4'b0;
        bus.data = '1;
        wait_done(cyc);
        chk("t5_lat", 32'(cyc), 32'(WIDTH - 1));
        chk("t5_id", 32'(bus.done_id), 32'h2);
        chk("t5_count", 32'(bus.match_count), 32'h2);
        @(negedge clk);

        // Randomized traffic with occasional resets, checked by the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                bus.req = 4'($urandom_range(0, 15));
                for (int i = 0; i < 4; i++) begin
                    case ($urandom_range(0, 4))
                        0:       w = 8'hB6;
                        1:       w = 8'hBB;
                        2:       w = 8'h5B;
                        default: w = 8'($urandom);
                    endcase
                    bus.data[i*WIDTH +: WIDTH] = w;
                end
            end
            reset = ($urandom_range(0, 299) == 0);
        end
        reset   = 1'b0;
        bus.req = 4'b0;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_arbiter.md
SEQ_DETECT_ARBITER -- requirements
Module: seq_detect_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: bits per job word.
REQ-002 Parameter PATTERN, default 4'b1011: 4-bit target sequence, MSB received first.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  4  per-requester job request; held high until its done.
REQ-006 data  input  4*WIDTH  requester i word at bits [WIDTH*i+WIDTH-1 : WIDTH*i].
REQ-007 grant  output  4  one-hot owner of the shared detector; all zero when idle.
REQ-008 busy  output  1  high while a job is in progress (any state except IDLE).
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 done_id  output  2  index of the requester whose job completed; valid with done.
REQ-011 match_count  output  3  number of overlapping PATTERN occurrences in the word; valid with done.

Function
REQ-012 The block SHALL share one serial pattern detector among 4 requesters, with FSM states IDLE, CLEAR, SHIFT, DRAIN, REPORT.
REQ-013 IDLE: if any req bit is set at an edge, the block SHALL select a requester by round-robin starting at (last_grant+1) mod 4, latch its word, set grant, and enter CLEAR; otherwise it SHALL stay in IDLE.
REQ-014 CLEAR (1 cycle): the block SHALL hold the detector in its start state and zero the match counter.
REQ-015 SHIFT (WIDTH cycles): the block SHALL feed the latched word to the detector MSB first, one bit per cycle, with the bit index decrementing from WIDTH-1 to 0.
REQ-016 The detector SHALL produce a registered one-cycle pulse in the cycle after the bit that completes PATTERN, and overlapping matches SHALL count.
REQ-017 DRAIN (1 cycle): the block SHALL capture the detector pulse produced by the last bit; counter increments are taken from detector pulses during SHIFT cycles 2..WIDTH and DRAIN.
REQ-018 REPORT (1 cycle): the block SHALL assert done, drive done_id and match_count, keep grant asserted, then return to IDLE.
REQ-019 Latency: for a req seen at edge k, grant SHALL rise in cycle k+1 and done SHALL be high in cycle k+WIDTH+3 (cycle k+11 for WIDTH=8).
REQ-020 Outside REPORT, done SHALL be 0, and match_count and done_id SHALL hold their last reported values.
REQ-021 Deassertion of the owner's req mid-job SHALL be ignored: the job completes and is reported.
REQ-022 Changes on the data bus after latching SHALL NOT affect the running job.
REQ-023 last_grant SHALL update on each grant, so a requester holding req through REPORT loses priority to any other pending requester.
REQ-024 Back-to-back jobs SHALL be separated by exactly one IDLE cycle.
REQ-025 match_count SHALL saturate at 7; this is unreachable for WIDTH=8, where the maximum is 5.

Reset
REQ-026 When reset is high at an edge, the block SHALL force IDLE from any state, including mid-SHIFT, and abort the job with no done.
REQ-027 Reset values: grant=0, busy=0, done=0, done_id=0, match_count=0, last_grant=3 (requester 0 wins first), detector in start state, bit index and counter zero.
REQ-028 Reset SHALL take priority over every other input in the same cycle.

Structure
REQ-029 Package seq_arb_pkg SHALL hold the state encoding (IDLE..REPORT), N_REQ=4, default WIDTH, default PATTERN and CNT_W=3.
REQ-030 The detector SHALL be a sub-module pattern_detector (ports clk, reset, clear, in, out; 4-state overlapping Moore-registered FSM parameterised by PATTERN), instantiated once.
REQ-031 The arbiter/sequencer FSM, round-robin logic, shift register and counter SHALL reside in seq_detect_arbiter.

Verification
REQ-032 The bench SHALL apply req=4'b0001 with data0=8'b1011_0110 and check grant=0001 for 11 cycles, done at cycle k+11, done_id=0, match_count=2 (overlap).
REQ-033 The bench SHALL apply req=4'b0010 with data1=8'h00 and check done_id=1, match_count=0; then data1=8'b1011_1011 and check match_count=2.
REQ-034 The bench SHALL hold req=4'b1111 from reset and check the grant order 0,1,2,3,0, with exactly one IDLE cycle between each done and the next grant.
REQ-035 The bench SHALL pulse reset in the 4th SHIFT cycle and check that grant, busy and done fall to 0 next cycle with no done; a rerun with 8'b1011_0110 SHALL yield 2, with no stale detector state.
REQ-036 The bench SHALL drop req mid-SHIFT and change the data bus, and check that done still pulses with the count of the originally latched word.
